// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the buffered result type for the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int AR_SIZE   = 7;   // physical register tag width
  localparam int FU_ARRAY  = 3;   // number of functional units
  localparam int CDB_PORTS = 2;   // number of broadcast ports
  localparam int BUF_DEPTH = 2;   // per-FU result buffer entries
  localparam int DATA_W    = 32;  // result value width
  localparam int SRC_W     = 2;   // width of the per-port source FU index

  // One buffered result as it travels from an FU to a broadcast port.
  typedef struct packed {
    logic [AR_SIZE-1:0] tag;
    logic [DATA_W-1:0]  value;
  } result_t;

  // Pointer width for a buffer of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-FU result buffer: small circular FIFO of result_t entries.
// flush_i empties the buffer at the edge and wins over push and pop.
// A push while full or a pop while empty is ignored.
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  result_t          data_i,
  output result_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  result_t          mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers one result stream per functional unit and
// broadcasts up to CDB_PORTS results per cycle in round-robin order.
//
// Handshake (FU side): a result transfers on a rising edge where
// fu_valid_in[i] && fu_ready_out[i]. fu_ready_out[i] depends only on the
// registered occupancy of buffer i, never on a same-cycle pop, so it carries
// no combinational path from the grant logic. A transferred result with tag 0
// completes the handshake but is dropped. The broadcast side has no ready:
// cdb_valid_out[p] is a one-cycle registered strobe.
//
// Buffer entries use the package result_t, so AR_SIZE must match the package.
module cdb_arbiter #(
  parameter int AR_SIZE   = cdb_arbiter_pkg::AR_SIZE,
  parameter int FU_ARRAY  = cdb_arbiter_pkg::FU_ARRAY,
  parameter int CDB_PORTS = cdb_arbiter_pkg::CDB_PORTS,
  parameter int BUF_DEPTH = cdb_arbiter_pkg::BUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_in,
  input  logic [FU_ARRAY-1:0]           fu_valid_in,
  input  logic [FU_ARRAY*AR_SIZE-1:0]   fu_tag_in,
  input  logic [FU_ARRAY*32-1:0]        fu_value_in,
  output logic [FU_ARRAY-1:0]           fu_ready_out,
  output logic [CDB_PORTS-1:0]          cdb_valid_out,
  output logic [CDB_PORTS*AR_SIZE-1:0]  cdb_tag_out,
  output logic [CDB_PORTS*32-1:0]       cdb_value_out,
  output logic [CDB_PORTS*2-1:0]        cdb_src_out
);

  localparam int RR_W  = (FU_ARRAY > 1) ? $clog2(FU_ARRAY) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int DW    = cdb_arbiter_pkg::DATA_W;
  localparam int SW    = cdb_arbiter_pkg::SRC_W;

  typedef cdb_arbiter_pkg::result_t result_t;

  // Buffer interface signals, one per FU.
  logic [FU_ARRAY-1:0] fifo_push;
  logic [FU_ARRAY-1:0] fifo_pop;
  logic [FU_ARRAY-1:0] fifo_full;
  logic [FU_ARRAY-1:0] fifo_empty;
  logic [CNT_W-1:0]    fifo_count [FU_ARRAY];
  result_t             fifo_din   [FU_ARRAY];
  result_t             fifo_head  [FU_ARRAY];
  logic                unused_full;

  // Round-robin pointer and grant results.
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [FU_ARRAY-1:0]  grant;
  logic [CDB_PORTS-1:0] port_vld;
  logic [RR_W-1:0]      port_fu [CDB_PORTS];
  logic [RR_W-1:0]      last_fu;
  logic [RR_W-1:0]      scan_idx;
  logic [RR_W:0]        scan_sum;
  logic                 found;

  // Registered broadcast outputs.
  logic [CDB_PORTS-1:0]         cdb_valid_q, cdb_valid_d;
  logic [CDB_PORTS*AR_SIZE-1:0] cdb_tag_q,   cdb_tag_d;
  logic [CDB_PORTS*DW-1:0]      cdb_value_q, cdb_value_d;
  logic [CDB_PORTS*SW-1:0]      cdb_src_q,   cdb_src_d;

  // Full is implied by the count compare used for ready.
  assign unused_full = ^fifo_full;

  for (genvar i = 0; i < FU_ARRAY; i++) begin : g_fu
    assign fifo_din[i]     = {fu_tag_in[i*AR_SIZE +: AR_SIZE], fu_value_in[i*DW +: DW]};
    assign fu_ready_out[i] = (fifo_count[i] < CNT_W'(BUF_DEPTH));
    // Tag 0 means "no destination": accept the handshake but store nothing.
    assign fifo_push[i]    = fu_valid_in[i] && fu_ready_out[i] &&
                             (fu_tag_in[i*AR_SIZE +: AR_SIZE] != '0);

    result_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush_in),
      .push_i  (fifo_push[i]),
      .pop_i   (fifo_pop[i]),
      .data_i  (fifo_din[i]),
      .head_o  (fifo_head[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_count[i])
    );
  end

  // Grant selection: each port in turn takes the first non-empty, not yet
  // granted buffer scanning from rr_ptr, so port 0 always holds the earliest grant.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    last_fu  = rr_ptr_q;
    scan_sum = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      port_fu[p] = '0;
    end
    for (int p = 0; p < CDB_PORTS; p++) begin
      found = 1'b0;
      for (int k = 0; k < FU_ARRAY; k++) begin
        scan_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
        if (scan_sum >= (RR_W+1)'(FU_ARRAY)) begin
          scan_sum = scan_sum - (RR_W+1)'(FU_ARRAY);
        end
        scan_idx = scan_sum[RR_W-1:0];
        if (!found && !fifo_empty[scan_idx] && !grant[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          port_vld[p]     = 1'b1;
          port_fu[p]      = scan_idx;
          last_fu         = scan_idx;
          found           = 1'b1;
        end
      end
    end
  end

  // Pops, pointer advance and next broadcast contents; flush clears everything.
  always_comb begin
    fifo_pop    = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = '0;
    cdb_tag_d   = '0;
    cdb_value_d = '0;
    cdb_src_d   = '0;
    if (flush_in) begin
      rr_ptr_d = '0;
    end else begin
      fifo_pop = grant;
      if (|grant) begin
        rr_ptr_d = (last_fu == RR_W'(FU_ARRAY - 1)) ? '0 : last_fu + 1'b1;
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (port_vld[p]) begin
          cdb_valid_d[p]                   = 1'b1;
          cdb_tag_d[p*AR_SIZE +: AR_SIZE]  = fifo_head[port_fu[p]].tag;
          cdb_value_d[p*DW +: DW]          = fifo_head[port_fu[p]].value;
          cdb_src_d[p*SW +: SW]            = SW'(port_fu[p]);
        end
      end
    end
  end

  // Pointer and broadcast registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid_out = cdb_valid_q;
  assign cdb_tag_out   = cdb_tag_q;
  assign cdb_value_out = cdb_value_q;
  assign cdb_src_out   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the buffering and round-robin broadcast.
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int AR    = 7;
  localparam int NFU   = 3;
  localparam int NP    = 2;
  localparam int DEPTH = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                flush_in;
  logic [NFU-1:0]      fu_valid_in;
  logic [NFU*AR-1:0]   fu_tag_in;
  logic [NFU*32-1:0]   fu_value_in;
  logic [NFU-1:0]      fu_ready_out;
  logic [NP-1:0]       cdb_valid_out;
  logic [NP*AR-1:0]    cdb_tag_out;
  logic [NP*32-1:0]    cdb_value_out;
  logic [NP*2-1:0]     cdb_src_out;

  cdb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .flush_in      (flush_in),
    .fu_valid_in   (fu_valid_in),
    .fu_tag_in     (fu_tag_in),
    .fu_value_in   (fu_value_in),
    .fu_ready_out  (fu_ready_out),
    .cdb_valid_out (cdb_valid_out),
    .cdb_tag_out   (cdb_tag_out),
    .cdb_value_out (cdb_value_out),
    .cdb_src_out   (cdb_src_out)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-FU expected queues and round-robin start index
  logic [AR-1:0] exp_q     [NFU][$];
  logic [31:0]   exp_val_q [NFU][$];
  int            model_rr;
  logic [NP-1:0] exp_valid;
  logic [AR-1:0] exp_tag   [NP];
  logic [31:0]   exp_value [NP];
  logic [1:0]    exp_src   [NP];
  logic [NFU-1:0] exp_ready;
  int            accept_cnt;
  int            exp_bcast;

  // Driver tasks
  task automatic set_idle();
    fu_valid_in = '0;
    fu_tag_in   = '0;
    fu_value_in = '0;
    flush_in    = 1'b0;
  endtask

  task automatic set_fu(input int i, input logic [AR-1:0] t, input logic [31:0] v);
    fu_valid_in[i]          = 1'b1;
    fu_tag_in[i*AR +: AR]   = t;
    fu_value_in[i*32 +: 32] = v;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NFU; i++) begin
      exp_q[i].delete();
      exp_val_q[i].delete();
    end
    model_rr  = 0;
    exp_valid = '0;
    exp_ready = '1;
    for (int p = 0; p < NP; p++) begin
      exp_tag[p]   = '0;
      exp_value[p] = '0;
      exp_src[p]   = '0;
    end
  endtask

  // Advance one clock edge, updating the model from the inputs present before it.
  task automatic tick();
    logic [NFU-1:0] acc;
    logic [AR-1:0]  in_tag [NFU];
    logic [31:0]    in_val [NFU];
    logic           fl;
    int             gcnt;
    int             gfu [NP];
    int             idx;
    fl   = flush_in;
    gcnt = 0;
    for (int i = 0; i < NFU; i++) begin
      acc[i]    = fu_valid_in[i] && (exp_q[i].size() < DEPTH);
      in_tag[i] = fu_tag_in[i*AR +: AR];
      in_val[i] = fu_value_in[i*32 +: 32];
    end
    for (int p = 0; p < NP; p++) gfu[p] = 0;
    for (int k = 0; k < NFU; k++) begin
      idx = (model_rr + k) % NFU;
      if (exp_q[idx].size() > 0 && gcnt < NP) begin
        gfu[gcnt] = idx;
        gcnt++;
      end
    end
    @(posedge clk);
    exp_valid = '0;
    for (int p = 0; p < NP; p++) begin
      exp_tag[p]   = '0;
      exp_value[p] = '0;
      exp_src[p]   = '0;
    end
    if (fl) begin
      for (int i = 0; i < NFU; i++) begin
        exp_q[i].delete();
        exp_val_q[i].delete();
      end
      model_rr = 0;
    end else begin
      for (int p = 0; p < gcnt; p++) begin
        exp_valid[p] = 1'b1;
        exp_tag[p]   = exp_q[gfu[p]].pop_front();
        exp_value[p] = exp_val_q[gfu[p]].pop_front();
        exp_src[p]   = 2'(gfu[p]);
        exp_bcast++;
      end
      if (gcnt > 0) model_rr = (gfu[gcnt-1] + 1) % NFU;
      for (int i = 0; i < NFU; i++) begin
        if (acc[i] && in_tag[i] != '0) begin
          exp_q[i].push_back(in_tag[i]);
          exp_val_q[i].push_back(in_val[i]);
          accept_cnt++;
        end
      end
    end
    for (int i = 0; i < NFU; i++) exp_ready[i] = (exp_q[i].size() < DEPTH);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    model_clear();
    #12;
    checks++;
    if (cdb_valid_out !== '0 || cdb_tag_out !== '0 || cdb_value_out !== '0 || cdb_src_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b tag=%h val=%h src=%h, want all zero",
               cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out);
    end
    checks++;
    if (fu_ready_out !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got %b want 111", fu_ready_out);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_idle();
    set_fu(1, 7'd5, 32'h1234);
    tick();
    set_idle();
    checks++;
    if (cdb_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL single_no_bypass: got valid %b want 00", cdb_valid_out);
    end
    tick();
    checks++;
    if (cdb_valid_out !== 2'b01 || cdb_tag_out[0 +: AR] !== 7'd5 ||
        cdb_value_out[0 +: 32] !== 32'h1234 || cdb_src_out[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL single_port0: got v=%b tag=%0d val=%h src=%0d, want v=01 tag=5 val=1234 src=1",
               cdb_valid_out, cdb_tag_out[0 +: AR], cdb_value_out[0 +: 32], cdb_src_out[1:0]);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin
      failures++;
      $display("FAIL single_rr_ptr: got %0d want 2", dut.rr_ptr_q);
    end
    tick();
    checks++;
    if (cdb_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL single_idle_after: got valid %b want 00", cdb_valid_out);
    end
  endtask

  task automatic test_contention();
    set_idle();
    flush_in = 1'b1;
    tick();
    set_idle();
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL contention_rr_start: got %0d want 0", dut.rr_ptr_q);
    end
    set_fu(0, 7'd10, 32'hA0);
    set_fu(1, 7'd11, 32'hA1);
    set_fu(2, 7'd12, 32'hA2);
    tick();
    set_idle();
    tick();
    checks++;
    if (cdb_valid_out !== 2'b11 || cdb_tag_out[0 +: AR] !== 7'd10 || cdb_src_out[1:0] !== 2'd0 ||
        cdb_tag_out[AR +: AR] !== 7'd11 || cdb_src_out[3:2] !== 2'd1 ||
        cdb_value_out[32 +: 32] !== 32'hA1) begin
      failures++;
      $display("FAIL contention_first: got v=%b tags=%0d,%0d src=%0d,%0d, want v=11 tags=10,11 src=0,1",
               cdb_valid_out, cdb_tag_out[0 +: AR], cdb_tag_out[AR +: AR], cdb_src_out[1:0], cdb_src_out[3:2]);
    end
    tick();
    checks++;
    if (cdb_valid_out !== 2'b01 || cdb_tag_out[0 +: AR] !== 7'd12 || cdb_src_out[1:0] !== 2'd2 ||
        cdb_tag_out[AR +: AR] !== '0) begin
      failures++;
      $display("FAIL contention_second: got v=%b tag0=%0d src0=%0d tag1=%0d, want v=01 tag0=12 src0=2 tag1=0",
               cdb_valid_out, cdb_tag_out[0 +: AR], cdb_src_out[1:0], cdb_tag_out[AR +: AR]);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL contention_rr_end: got %0d want 0", dut.rr_ptr_q);
    end
  endtask

  // mode 0: every FU presents a result every cycle; mode 1: random valid, tags, flushes
  task automatic test_traffic(input int cycles, input int mode);
    int  act_bcast;
    bit  saw_low;
    int  start_accept;
    int  start_bcast;
    act_bcast    = 0;
    saw_low      = 1'b0;
    start_accept = accept_cnt;
    start_bcast  = exp_bcast;
    for (int c = 0; c < cycles + 8; c++) begin
      set_idle();
      if (c < cycles) begin
        for (int i = 0; i < NFU; i++) begin
          if (mode == 0) begin
            set_fu(i, 7'($urandom_range(1, 127)), $urandom);
          end else if ($urandom_range(0, 99) < 60) begin
            set_fu(i, ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127)), $urandom);
          end
        end
        if (mode == 1 && $urandom_range(0, 24) == 0) flush_in = 1'b1;
      end
      tick();
      act_bcast += $countones(cdb_valid_out);
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (cdb_valid_out[p] !== exp_valid[p] || cdb_tag_out[p*AR +: AR] !== exp_tag[p] ||
            cdb_value_out[p*32 +: 32] !== exp_value[p] || cdb_src_out[p*2 +: 2] !== exp_src[p]) begin
          failures++;
          $display("FAIL traffic%0d_port%0d cycle %0d: got v=%b tag=%0d val=%h src=%0d, want v=%b tag=%0d val=%h src=%0d",
                   mode, p, c, cdb_valid_out[p], cdb_tag_out[p*AR +: AR], cdb_value_out[p*32 +: 32],
                   cdb_src_out[p*2 +: 2], exp_valid[p], exp_tag[p], exp_value[p], exp_src[p]);
        end
      end
      checks++;
      if (fu_ready_out !== exp_ready) begin
        failures++;
        $display("FAIL traffic%0d_ready cycle %0d: got %b want %b", mode, c, fu_ready_out, exp_ready);
      end
      if (fu_ready_out[0] == 1'b0 && exp_q[0].size() == DEPTH) saw_low = 1'b1;
    end
    if (mode == 0) begin
      checks++;
      if (!saw_low) begin
        failures++;
        $display("FAIL backpressure_ready0_drop: got no cycle with ready0=0 at 2 entries, want at least one");
      end
      checks++;
      if (act_bcast !== accept_cnt - start_accept) begin
        failures++;
        $display("FAIL backpressure_count: got %0d broadcasts want %0d", act_bcast, accept_cnt - start_accept);
      end
    end else begin
      checks++;
      if (act_bcast !== exp_bcast - start_bcast) begin
        failures++;
        $display("FAIL random_count: got %0d broadcasts want %0d", act_bcast, exp_bcast - start_bcast);
      end
    end
  endtask

  task automatic test_tag0();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      set_fu(2, 7'd0, 32'hFFFF);
      tick();
      checks++;
      if (fu_ready_out[2] !== 1'b1) begin
        failures++;
        $display("FAIL tag0_ready cycle %0d: got %b want 1", c, fu_ready_out[2]);
      end
    end
    set_idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (cdb_valid_out !== 2'b00) begin
        failures++;
        $display("FAIL tag0_no_broadcast cycle %0d: got valid %b want 00", c, cdb_valid_out);
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      for (int i = 0; i < NFU; i++) set_fu(i, 7'($urandom_range(1, 127)), $urandom);
      tick();
    end
    set_idle();
    flush_in = 1'b1;
    set_fu(0, 7'd33, 32'h3333);
    tick();
    set_idle();
    checks++;
    if (cdb_valid_out !== 2'b00 || fu_ready_out !== 3'b111) begin
      failures++;
      $display("FAIL flush_clear: got valid %b ready %b, want 00 and 111", cdb_valid_out, fu_ready_out);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL flush_rr_ptr: got %0d want 0", dut.rr_ptr_q);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (cdb_valid_out !== 2'b00) begin
        failures++;
        $display("FAIL flush_no_stale cycle %0d: got valid %b want 00", c, cdb_valid_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      for (int i = 0; i < NFU; i++) set_fu(i, 7'($urandom_range(1, 127)), $urandom);
      tick();
    end
    set_idle();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if (cdb_valid_out !== '0 || cdb_tag_out !== '0 || cdb_value_out !== '0 || cdb_src_out !== '0 ||
        fu_ready_out !== 3'b111) begin
      failures++;
      $display("FAIL midreset_clear: got v=%b tag=%h val=%h src=%h ready=%b, want zeros and ready 111",
               cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out, fu_ready_out);
    end
    @(negedge clk);
    rst = 1'b0;
    set_fu(1, 7'd9, 32'hABCD);
    tick();
    set_idle();
    checks++;
    if (cdb_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL midreset_no_stale: got valid %b want 00", cdb_valid_out);
    end
    tick();
    checks++;
    if (cdb_valid_out !== 2'b01 || cdb_tag_out[0 +: AR] !== 7'd9 ||
        cdb_value_out[0 +: 32] !== 32'hABCD || cdb_src_out[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL midreset_first_push: got v=%b tag=%0d val=%h src=%0d, want v=01 tag=9 val=abcd src=1",
               cdb_valid_out, cdb_tag_out[0 +: AR], cdb_value_out[0 +: 32], cdb_src_out[1:0]);
    end
    tick();
    checks++;
    if (cdb_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL midreset_drained: got valid %b want 00", cdb_valid_out);
    end
  endtask

  initial begin
    accept_cnt = 0;
    exp_bcast  = 0;
    test_reset();
    test_single();
    test_contention();
    test_traffic(60, 0);
    test_tag0();
    test_flush();
    test_traffic(400, 1);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
